// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 5;
  localparam int unsigned DEF_FIFO_DEPTH = 2;
  localparam int unsigned DEF_STARVE_LIM = 4;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_RUN,
    CLR_DONE
  } clr_state_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback / multi-cycle / register-file write-port bundle for rf_write_arbiter.
interface rf_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stall;
  logic              mc_valid;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic              mc_ready;
  logic              mc_pend;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd;

  modport master (
    output wb_we, wb_addr, wb_data, mc_valid, mc_addr, mc_data, clr_start,
    input  wb_stall, mc_ready, mc_pend, clr_busy, clr_done, rf_we, rf_a3, rf_wd
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, mc_valid, mc_addr, mc_data, clr_start,
    output wb_stall, mc_ready, mc_pend, clr_busy, clr_done, rf_we, rf_a3, rf_wd
  );
endinterface

// File: rtl/rf_wr_fifo.sv
// Small sync FIFO of {addr,data} with per-entry address/valid taps for hazard compare.
module rf_wr_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [ADDR_W-1:0] ent_addr_o [DEPTH],
  output logic [DEPTH-1:0]  ent_vld_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      if (pop_i) begin
        rd_q        <= ptr_inc(rd_q);
        vld_q[rd_q] <= 1'b0;
      end
      if (push_i) begin
        wr_q        <= ptr_inc(wr_q);
        vld_q[wr_q] <= 1'b1;
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_q] <= push_addr_i;
      data_q[wr_q] <= push_data_i;
    end
  end

  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign head_addr_o = addr_q[rd_q];
  assign head_data_o = data_q[rd_q];
  assign ent_addr_o  = addr_q;
  assign ent_vld_o   = vld_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between core writeback and a buffered multi-cycle unit.
// The full-register clear sequencer is built only when RF_ARB_CLEAR_EN is defined.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic              fifo_full, fifo_empty, push, pop, bypass, mc_ready, mc_fire, pend;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] ent_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              stall_q;
  logic              clr_run, clr_busy, clr_done;
  logic [IDX_W-1:0]  clr_idx;
  logic              port_we;
  logic [ADDR_W-1:0] port_a;
  logic [DATA_W-1:0] port_d;

  rf_wr_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (push),
    .push_addr_i (bus.mc_addr),
    .push_data_i (bus.mc_data),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .ent_addr_o  (ent_addr),
    .ent_vld_o   (ent_vld)
  );

`ifdef RF_ARB_CLEAR_EN
  clr_state_e       clr_st_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic             clr_busy_q, clr_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_st_q   <= CLR_IDLE;
      clr_idx_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      unique case (clr_st_q)
        CLR_IDLE: if (bus.clr_start) begin
          clr_st_q   <= CLR_RUN;
          clr_idx_q  <= '0;
          clr_busy_q <= 1'b1;
        end
        CLR_RUN: begin
          clr_idx_q <= clr_idx_q + IDX_W'(1);
          if (clr_idx_q == IDX_W'(NUM_REGS - 1)) begin
            clr_st_q   <= CLR_DONE;
            clr_done_q <= 1'b1;
          end
        end
        CLR_DONE: begin
          clr_st_q   <= CLR_IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
        default: clr_st_q <= CLR_IDLE;
      endcase
    end
  end

  assign clr_run  = (clr_st_q == CLR_RUN);
  assign clr_idx  = clr_idx_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
`else
  logic unused_clr_start;
  assign unused_clr_start = bus.clr_start;
  assign clr_run  = 1'b0;
  assign clr_idx  = '0;
  assign clr_busy = 1'b0;
  assign clr_done = 1'b0;
`endif

  // Ready ignores a same-cycle drain so it never depends on the port decision.
  assign mc_ready = rst & ~fifo_full & ~clr_busy;
  assign mc_fire  = bus.mc_valid & mc_ready;

  always_comb begin
    port_we = 1'b0;
    port_a  = '0;
    port_d  = '0;
    pop     = 1'b0;
    bypass  = 1'b0;
    if (clr_run) begin
      port_we = 1'b1;
      port_a  = ADDR_W'(clr_idx);
    end else if (stall_q && !fifo_empty) begin
      port_we = 1'b1;
      port_a  = head_addr;
      port_d  = head_data;
      pop     = 1'b1;
    end else if (bus.wb_we && !stall_q) begin
      port_we = 1'b1;
      port_a  = bus.wb_addr;
      port_d  = bus.wb_data;
    end else if (!fifo_empty) begin
      port_we = 1'b1;
      port_a  = head_addr;
      port_d  = head_data;
      pop     = 1'b1;
    end else if (mc_fire) begin
      port_we = 1'b1;
      port_a  = bus.mc_addr;
      port_d  = bus.mc_data;
      bypass  = 1'b1;
    end
  end

  assign push = mc_fire & ~bypass;

  // Counts cycles a waiting head is denied the port; held while the clear owns it.
  always_comb begin
    starve_d = starve_q;
    if (!clr_run) begin
      if (pop || fifo_empty)                        starve_d = '0;
      else if (starve_q != CNT_W'(STARVE_LIM))      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= (starve_d == CNT_W'(STARVE_LIM));
    end
  end

  always_comb begin
    pend = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++)
      if (ent_vld[i] && (ent_addr[i] == bus.wb_addr)) pend = 1'b1;
  end

  assign bus.rf_we    = rst & port_we;
  assign bus.rf_a3    = port_a;
  assign bus.rf_wd    = port_d;
  assign bus.wb_stall = stall_q | clr_run;
  assign bus.mc_ready = mc_ready;
  assign bus.mc_pend  = rst & pend;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 2, LIM = 4;
`ifdef RF_ARB_CLEAR_EN
  localparam bit CLR_ON = 1'b1;
`else
  localparam bit CLR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  rf_write_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  int   cnt, phase, cidx;
  bit   stl;
  logic [DW-1:0] rf [32];
  int   total, bad;

  logic          e_we, e_pop, e_push, e_ready, e_pend, e_stall;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_d;
  logic          o_we;
  logic [AW-1:0] o_a;
  logic [DW-1:0] o_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic cs);
    bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd;
    bus.mc_valid = mv; bus.mc_addr = ma; bus.mc_data = md;
    bus.clr_start = cs;
  endtask

  // Port owner chosen by the priority list: clear, starved head, core, head, bypass.
  task automatic model_eval();
    bit fire, byp;
    e_ready = (q.size() < DEPTH) && (phase == 0);
    fire    = bus.mc_valid && e_ready;
    e_stall = (phase == 1) || stl;
    e_pend  = 1'b0;
    foreach (q[i]) if (q[i].a == bus.wb_addr) e_pend = 1'b1;
    e_we = 1'b0; e_a = '0; e_d = '0; e_pop = 1'b0; byp = 1'b0;
    if (phase == 1) begin
      e_we = 1'b1; e_a = AW'(cidx); e_d = '0;
    end else if (stl && q.size() > 0) begin
      e_we = 1'b1; e_a = q[0].a; e_d = q[0].d; e_pop = 1'b1;
    end else if (bus.wb_we && !stl) begin
      e_we = 1'b1; e_a = bus.wb_addr; e_d = bus.wb_data;
    end else if (q.size() > 0) begin
      e_we = 1'b1; e_a = q[0].a; e_d = q[0].d; e_pop = 1'b1;
    end else if (fire) begin
      e_we = 1'b1; e_a = bus.mc_addr; e_d = bus.mc_data; byp = 1'b1;
    end
    e_push = fire && !byp;
  endtask

  task automatic model_update();
    bit nonempty;
    nonempty = (q.size() > 0);
    if (phase != 1) begin
      if (e_pop || !nonempty) cnt = 0;
      else                    cnt = cnt + 1;
    end
    if (e_pop) void'(q.pop_front());
    if (e_push) q.push_back('{a: bus.mc_addr, d: bus.mc_data});
    stl = (cnt == LIM);
    case (phase)
      0: if (CLR_ON && bus.clr_start) begin phase = 1; cidx = 0; end
      1: if (cidx == 31) phase = 2; else cidx++;
      default: phase = 0;
    endcase
  endtask

  task automatic cycle();
    #1;
    model_eval();
    o_we = bus.rf_we; o_a = bus.rf_a3; o_d = bus.rf_wd;
    chk("rf_we", bus.rf_we, e_we);
    if (e_we) begin
      chk("rf_a3", bus.rf_a3, e_a);
      chk("rf_wd", bus.rf_wd, e_d);
    end
    chk("wb_stall", bus.wb_stall, e_stall);
    chk("mc_ready", bus.mc_ready, e_ready);
    chk("mc_pend", bus.mc_pend, e_pend);
    chk("clr_busy", bus.clr_busy, phase != 0);
    chk("clr_done", bus.clr_done, phase == 2);
    @(posedge clk);
    model_update();
    if (o_we === 1'b1) rf[o_a] = o_d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_rf_we", bus.rf_we, 1'b0);
    chk("rst_stall", bus.wb_stall, 1'b0);
    chk("rst_ready", bus.mc_ready, 1'b0);
    chk("rst_busy", bus.clr_busy, 1'b0);
    chk("rst_done", bus.clr_done, 1'b0);
    chk("rst_pend", bus.mc_pend, 1'b0);
    q.delete(); cnt = 0; stl = 1'b0; phase = 0; cidx = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    foreach (rf[i]) rf[i] = '1;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2, 1'b0);
    do_reset();

    // bypass: lone mc write goes straight to the port
    drive(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0);
    #1;
    chk("byp_we", bus.rf_we, 1'b1);
    chk("byp_a3", bus.rf_a3, 5'd7);
    chk("byp_wd", bus.rf_wd, 32'hA5A5_A5A5);
    cycle();

    // starvation: core writes every cycle, two buffered mc writes
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 5'($urandom), $urandom, (k < 2), (k == 0) ? 5'd3 : 5'd4,
            32'h3000_0000 + k, 1'b0);
      if (k == 2) begin #1; chk("full_ready", bus.mc_ready, 1'b0); end
      if (k == 5) begin
        #1; chk("starve1_stall", bus.wb_stall, 1'b1); chk("starve1_a3", bus.rf_a3, 5'd3);
      end
      if (k == 10) begin
        #1; chk("starve2_stall", bus.wb_stall, 1'b1); chk("starve2_a3", bus.rf_a3, 5'd4);
      end
      cycle();
    end

    // pending-address compare
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99, 1'b0);
    cycle();
    drive(1'b1, 5'd9, 32'h12, 1'b0, 5'd0, '0, 1'b0);
    #1; chk("pend_hit", bus.mc_pend, 1'b1);
    cycle();
    drive(1'b1, 5'd10, 32'h13, 1'b0, 5'd0, '0, 1'b0);
    #1; chk("pend_miss", bus.mc_pend, 1'b0);
    cycle();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
    for (int k = 0; k < 3; k++) cycle();

    // clear sequence under random traffic
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1);
    cycle();
    for (int k = 0; k < 40; k++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom, 1'b0);
      if (CLR_ON && phase == 2) foreach (rf[i]) chk("rf_zero", rf[i], '0);
      cycle();
    end

    // reset in the middle of a clear with one buffered entry
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd12, 32'hC, 1'b0);
    cycle();
    drive(1'b1, 5'd2, 32'h23, 1'b0, 5'd0, '0, 1'b1);
    cycle();
    drive(1'b1, 5'd2, 32'h24, 1'b0, 5'd0, '0, 1'b0);
    for (int k = 0; k < 40 && CLR_ON && !(phase == 1 && cidx == 15); k++) cycle();
    if (CLR_ON) chk("at_idx15", bus.rf_a3, 5'd15);
    drive(1'b0, 5'd12, '0, 1'b0, 5'd0, '0, 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) cycle();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 5) < 3, 5'($urandom % 8), $urandom, 1'($urandom), 5'($urandom % 8),
            $urandom, ($urandom % 64) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
